wb_timer: RTL and testbench

Wishbone classic slave (responder) timer/compare peripheral on the SoC interconnect, answering cycles driven by wishbone_controller through wb_intercon.
- Provides a prescaled 32-bit up-counter, compare match, auto-reload and a level interrupt.
- Registered single-cycle ack; error termination for unmapped offsets.
- Gives software a time base and the pipeline a real multi-cycle slave to stall on.

---
 rtl/wb_timer_pkg.sv | 35 +++
 rtl/wb_timer_prescaler.sv | 35 +++
 rtl/wb_timer.sv | 168 ++++++++++++++++
 tb/tb_wb_timer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register offsets, CTRL bit
// positions, bus FSM states and the byte-lane write-merge helper.
package wb_timer_pkg;

    localparam logic [31:0] REG_CTRL     = 32'h00;
    localparam logic [31:0] REG_PRESCALE = 32'h04;
    localparam logic [31:0] REG_COUNT    = 32'h08;
    localparam logic [31:0] REG_COMPARE  = 32'h0C;
    localparam logic [31:0] REG_STATUS   = 32'h10;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_BITS        = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_t;

    // Replace only the byte lanes selected by sel, keep the rest of old.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescale counter: counts 0..prescale while enabled and emits a one-cycle
// tick on the wrap; a clear request restarts the count from zero.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pcnt_reg;
    logic                      at_limit;

    // >= so that lowering PRESCALE below the running count wraps at once
    assign at_limit = (pcnt_reg >= prescale);
    assign tick     = en && !clear && at_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_reg <= '0;
        end else if (clear) begin
            pcnt_reg <= '0;
        end else if (en) begin
            if (at_limit) begin
                pcnt_reg <= '0;
            end else begin
                pcnt_reg <= pcnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic timer/compare slave: prescaled 32-bit up-counter with
// compare match, optional auto-reload and a level interrupt.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  irq_o
);

    bus_state_t                state_reg, state_next;
    logic                      ack_reg, ack_next;
    logic                      err_reg, err_next;
    logic [31:0]               dat_reg, dat_next;

    logic [CTRL_BITS-1:0]      ctrl_reg, ctrl_next;
    logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
    logic [31:0]               count_reg, count_next;
    logic [31:0]               compare_reg, compare_next;
    logic                      match_reg, match_next;
    logic                      irq_reg, irq_next;

    logic [31:0]               byte_off;
    logic                      hit_ctrl, hit_prescale, hit_count, hit_compare, hit_status;
    logic                      addr_valid;
    logic                      req;
    logic                      wr;
    logic [31:0]               rd_data;
    logic [31:0]               wr_merged;
    logic                      tick;
    logic                      match_set;
    logic                      unused_bits;

    assign byte_off     = 32'({wb_adr_i[ADDR_WIDTH-1:2], 2'b00});
    assign hit_ctrl     = (byte_off == REG_CTRL);
    assign hit_prescale = (byte_off == REG_PRESCALE);
    assign hit_count    = (byte_off == REG_COUNT);
    assign hit_compare  = (byte_off == REG_COMPARE);
    assign hit_status   = (byte_off == REG_STATUS);
    assign addr_valid   = hit_ctrl | hit_prescale | hit_count | hit_compare | hit_status;

    // A request is only taken in IDLE; stb held through RESP is ignored.
    assign req = wb_cyc_i && wb_stb_i && (state_reg == IDLE);
    assign wr  = req && wb_we_i && addr_valid;

    always_comb begin
        rd_data = '0;
        if (hit_ctrl)     rd_data = 32'(ctrl_reg);
        if (hit_prescale) rd_data = 32'(prescale_reg);
        if (hit_count)    rd_data = count_reg;
        if (hit_compare)  rd_data = compare_reg;
        if (hit_status)   rd_data = {31'b0, match_reg};
    end

    assign wr_merged = merge_bytes(rd_data, wb_dat_i, wb_sel_i);

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ctrl_reg[CTRL_EN]),
        .clear   (wr && (hit_ctrl || hit_prescale)),
        .prescale(prescale_reg),
        .tick    (tick)
    );

    assign match_set = tick && (count_reg == compare_reg);

    always_comb begin
        ctrl_next     = ctrl_reg;
        prescale_next = prescale_reg;
        compare_next  = compare_reg;
        count_next    = count_reg;
        match_next    = match_reg;

        if (wr && hit_ctrl)     ctrl_next     = wr_merged[CTRL_BITS-1:0];
        if (wr && hit_prescale) prescale_next = wr_merged[PRESCALE_WIDTH-1:0];
        if (wr && hit_compare)  compare_next  = wr_merged;

        if (tick) begin
            if (match_set && ctrl_reg[CTRL_AUTO_RELOAD]) begin
                count_next = '0;
            end else begin
                count_next = count_reg + 32'd1;
            end
        end
        // A bus write to COUNT overrides the tick update.
        if (wr && hit_count) count_next = wr_merged;

        if (wr && hit_status && wb_sel_i[0] && wb_dat_i[0]) match_next = 1'b0;
        if (match_set) match_next = 1'b1;

        irq_next = match_next && ctrl_next[CTRL_IRQ_EN];
    end

    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        dat_next   = '0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = RESP;
                    if (addr_valid) begin
                        ack_next = 1'b1;
                        dat_next = rd_data;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            dat_reg      <= '0;
            ctrl_reg     <= '0;
            prescale_reg <= '0;
            count_reg    <= '0;
            compare_reg  <= '0;
            match_reg    <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            dat_reg      <= dat_next;
            ctrl_reg     <= ctrl_next;
            prescale_reg <= prescale_next;
            count_reg    <= count_next;
            compare_reg  <= compare_next;
            match_reg    <= match_next;
            irq_reg      <= irq_next;
        end
    end

    assign wb_dat_o = dat_reg;
    assign wb_ack_o = ack_reg;
    assign wb_err_o = err_reg;
    assign irq_o    = irq_reg;

    assign unused_bits = ^{wb_adr_i[1:0], wr_merged};

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: bus timing, error termination, byte lanes,
// prescaled counting, compare/auto-reload, collisions, wrap and hold.
module tb_wb_timer;

    logic        clk;
    logic        reset_n;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [7:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    wb_timer #(
        .ADDR_WIDTH    (8),
        .PRESCALE_WIDTH(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_we_i (wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_sel_i(wb_sel_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o),
        .irq_o   (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access; called at posedge+1, returns at posedge+1 two cycles later.
    task automatic xfer(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdat, input logic exp_err,
                        input logic chk_dat, input logic [31:0] exp_dat, input string tag);
        logic [31:0] got;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = wdat;
        @(posedge clk);
        #1;
        got = wb_dat_o;
        $display("xfer %s we=%0d adr=0x%02h sel=%b wdat=0x%08h ack=%0d err=%0d rdat=0x%08h",
                 tag, we, adr, sel, wdat, wb_ack_o, wb_err_o, got);
        chk({tag, "_ack"}, 32'(wb_ack_o), 32'(!exp_err));
        chk({tag, "_err"}, 32'(wb_err_o), 32'(exp_err));
        if (chk_dat) chk({tag, "_data"}, got, exp_dat);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, 32'({wb_ack_o, wb_err_o}), 32'd0);
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] wdat, input string tag);
        xfer(1'b1, adr, 4'hF, wdat, 1'b0, 1'b0, 32'd0, tag);
    endtask

    task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input string tag);
        xfer(1'b0, adr, 4'hF, 32'd0, 1'b0, 1'b1, exp, tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_sel_i = '0;
        wb_dat_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {wb_dat_o[28:0], wb_ack_o, wb_err_o, irq_o}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        rd(8'h08, 32'h0000_0000, "rd_count_after_reset");
        wr(8'h0C, 32'h0000_0005, "wr_compare");
        rd(8'h0C, 32'h0000_0005, "rd_compare");
        xfer(1'b0, 8'h20, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0, "rd_unmapped");
        xfer(1'b1, 8'h24, 4'hF, 32'h1234, 1'b1, 1'b0, 32'd0, "wr_unmapped");
        rd(8'h0C, 32'h0000_0005, "rd_compare_after_err");

        // Asynchronous reset asserted in the middle of a response cycle.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 8'h0C;
        wb_sel_i = 4'hF;
        @(posedge clk);
        #1;
        chk("pre_async_ack", 32'(wb_ack_o), 32'd1);
        chk("pre_async_dat", wb_dat_o, 32'h0000_0005);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {wb_dat_o[28:0], wb_ack_o, wb_err_o, irq_o}, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(8'h0C, 32'h0000_0000, "rd_compare_after_async_reset");

        xfer(1'b1, 8'h0C, 4'b0101, 32'hAABB_CCDD, 1'b0, 1'b0, 32'd0, "wr_compare_sel0101");
        rd(8'h0C, 32'h00BB_00DD, "rd_compare_sel0101");
        xfer(1'b1, 8'h0C, 4'b0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, "wr_compare_sel0000");
        rd(8'h0C, 32'h00BB_00DD, "rd_compare_sel0000");
        wr(8'h04, 32'hFFFF_FFFF, "wr_prescale_all");
        rd(8'h04, 32'h0000_FFFF, "rd_prescale_all");
        wr(8'h00, 32'hFFFF_FFF8, "wr_ctrl_upper");
        rd(8'h00, 32'h0000_0000, "rd_ctrl_upper");

        // Count / match / auto-reload: one tick every two cycles.
        wr(8'h04, 32'd1, "cnt_prescale");
        wr(8'h0C, 32'd3, "cnt_compare");
        wr(8'h08, 32'd0, "cnt_count");
        wr(8'h10, 32'd1, "cnt_status_clr");
        wr(8'h00, 32'h7, "cnt_ctrl_on");
        rd(8'h08, 32'd0, "cnt_read0");
        rd(8'h08, 32'd1, "cnt_read1");
        rd(8'h08, 32'd2, "cnt_read2");
        chk("cnt_irq_before_match", 32'(irq_o), 32'd0);
        rd(8'h08, 32'd3, "cnt_read3");
        chk("cnt_irq_after_match", 32'(irq_o), 32'd1);
        rd(8'h08, 32'd0, "cnt_reload");
        rd(8'h10, 32'd1, "cnt_status_set");
        wr(8'h10, 32'd1, "cnt_w1c");
        chk("cnt_irq_cleared", 32'(irq_o), 32'd0);
        rd(8'h10, 32'd0, "cnt_status_cleared");

        // COUNT write on a tick cycle (PRESCALE = 0 ticks every cycle).
        wr(8'h00, 32'h0, "col_ctrl_off");
        wr(8'h0C, 32'hFFFF_0000, "col_compare");
        wr(8'h10, 32'd1, "col_status_clr");
        wr(8'h04, 32'd0, "col_prescale");
        wr(8'h08, 32'h50, "col_count_init");
        wr(8'h00, 32'h1, "col_ctrl_on");
        wr(8'h08, 32'h100, "col_count_on_tick");
        rd(8'h08, 32'h101, "col_count_read");

        // W1C on the same edge as a new match: match stays set.
        wr(8'h00, 32'h0, "w1c_ctrl_off");
        wr(8'h0C, 32'h200, "w1c_compare");
        wr(8'h08, 32'h1FF, "w1c_count");
        wr(8'h10, 32'd1, "w1c_status_clr");
        rd(8'h10, 32'd0, "w1c_status_zero");
        wr(8'h00, 32'h1, "w1c_ctrl_on");
        wr(8'h10, 32'd1, "w1c_on_match");
        rd(8'h10, 32'd1, "w1c_status_kept");
        chk("w1c_irq_disabled", 32'(irq_o), 32'd0);

        // Wrap without reload, then hold with en = 0.
        wr(8'h00, 32'h0, "wrap_ctrl_off");
        wr(8'h0C, 32'h10, "wrap_compare");
        wr(8'h08, 32'hFFFF_FFFF, "wrap_count");
        wr(8'h10, 32'd1, "wrap_status_clr");
        wr(8'h00, 32'h1, "wrap_ctrl_on");
        rd(8'h08, 32'h0, "wrap_count_zero");
        rd(8'h10, 32'h0, "wrap_status_zero");
        wr(8'h00, 32'h0, "hold_ctrl_off");
        wr(8'h08, 32'h1234, "hold_count");
        repeat (20) @(posedge clk);
        #1;
        rd(8'h08, 32'h1234, "hold_count_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
